// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with CTRL/PRESET/COUNT registers and level irq
module timer_dev #(
  parameter logic [31:0] BASE = 32'h00007f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, CNT, INT} state_t;

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_flag, flag_n;
  logic        sel, wr_en;
  logic [1:0]  off;
  logic        unused_addr_lsb;

  assign sel             = (addr[31:4] == BASE[31:4]);
  assign off             = addr[3:2];
  assign wr_en           = sel && (byteen == 4'b1111);
  assign unused_addr_lsb = ^addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= flag_n;
    end
  end

  // FSM works from pre-edge register values; bus writes are applied afterwards so they win.
  always_comb begin
    state_n  = state;
    ctrl_n   = ctrl;
    preset_n = preset;
    count_n  = count;
    flag_n   = irq_flag;
    case (state)
      IDLE: begin
        if (ctrl[0]) begin
          count_n = preset;
          state_n = CNT;
        end
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n = '0;
          flag_n  = 1'b1;
          state_n = INT;
        end
      end
      INT: begin
        state_n = IDLE;
        if (ctrl[2:1] == 2'b01) flag_n = 1'b0;
        else                    ctrl_n[0] = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (wr_en && off == 2'd0) begin
      ctrl_n = wdata[3:0];
      flag_n = 1'b0;
    end
    if (wr_en && off == 2'd1) preset_n = wdata;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        2'd0:    rdata = {28'd0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = '0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - scoreboard bench for timer_dev: stimulus queues expected rdata/irq, monitor compares
module tb_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h00007f00;
  localparam logic [31:0] A_PRE  = 32'h00007f04;
  localparam logic [31:0] A_CNT  = 32'h00007f08;
  localparam logic [31:0] A_UNM  = 32'h00007f0c;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  logic [32:0] exp_q[$];
  string       name_q[$];
  logic        mon_valid;
  logic        end_req;
  int          n_checks;
  int          n_fail;

  timer_dev #(.BASE(32'h00007f00)) dut (
    .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_checks = 0;
    n_fail   = 0;
  end

  // Monitor: every cycle the bench presents a read, compare {irq, rdata} against the queue head.
  always @(negedge clk) begin
    if (mon_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: rdata=%h irq=%b with no expected entry", rdata, irq);
      end else begin
        logic [32:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({irq, rdata} !== e) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h irq=%b, required rdata=%h irq=%b",
                   nm, rdata, irq, e[31:0], e[32]);
        end
      end
    end
    if (end_req) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] er, input logic ei, input string nm);
    exp_q.push_back({ei, er});
    name_q.push_back(nm);
  endtask

  task automatic wr_be(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be; mon_valid = 1'b0;
    cyc();
    byteen = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_be(a, d, 4'b1111);
  endtask

  task automatic wrchk(input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ei, input string nm);
    addr = a; wdata = d; byteen = 4'b1111;
    push(er, ei, nm);
    mon_valid = 1'b1;
    cyc();
    byteen = 4'b0000; mon_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] er, input logic ei, input string nm);
    addr = a; byteen = 4'b0000;
    push(er, ei, nm);
    mon_valid = 1'b1;
    cyc();
    mon_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required summary before it");
    $fatal(1);
  end

  initial begin
    int os_cnt[6];
    int ar_cnt[11];
    int ar_irq[11];
    int im_cnt[5];
    reset = 1'b1; addr = '0; byteen = '0; wdata = '0;
    mon_valid = 1'b0; end_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    rd(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
    rd(A_PRE,  32'h0, 1'b0, "rst_preset");
    rd(A_CNT,  32'h0, 1'b0, "rst_count");
    rd(A_UNM,  32'h0, 1'b0, "rst_unmapped");

    // one-shot, PRESET=5
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    rd(A_CNT, 32'd0, 1'b0, "os_cnt_t0");
    os_cnt = '{5, 4, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++)
      rd(A_CNT, os_cnt[i], (i == 5), $sformatf("os_cnt_t%0d", i + 1));
    rd(A_CTRL, 32'h8, 1'b1, "os_en_cleared");
    rd(A_CTRL, 32'h8, 1'b1, "os_irq_held");
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, 32'h8, 1'b0, "os_irq_cleared");

    // auto-reload, PRESET=3: period 5
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    ar_cnt = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    ar_irq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 11; i++)
      rd(A_CNT, ar_cnt[i], ar_irq[i][0], $sformatf("ar_cnt_t%0d", i));
    wr(A_CTRL, 32'h3);
    im_cnt = '{2, 1, 0, 0, 3};
    for (int i = 0; i < 5; i++)
      rd(A_CNT, im_cnt[i], 1'b0, $sformatf("ar_masked_t%0d", i));
    wr(A_CTRL, 32'h0);
    rd(A_CNT, 32'd1, 1'b0, "stop_last_dec");
    rd(A_CNT, 32'd1, 1'b0, "stop_frozen_a");
    rd(A_CNT, 32'd1, 1'b0, "stop_frozen_b");

    // ignored writes
    wr_be(A_CTRL, 32'h9, 4'b0011);
    rd(A_CTRL, 32'h0, 1'b0, "ign_partial_be");
    wr(A_CNT, 32'h1234);
    rd(A_CNT, 32'd1, 1'b0, "ign_count_wr");
    wr(32'h00007f20, 32'h9);
    wr(32'h00007f24, 32'h55);
    rd(32'h00007f20, 32'h0, 1'b0, "ign_unsel_rdata");
    rd(A_CTRL, 32'h0, 1'b0, "ign_unsel_ctrl");
    rd(A_PRE, 32'd3, 1'b0, "ign_unsel_preset");
    wr(A_UNM, 32'hffff);
    rd(A_UNM, 32'h0, 1'b0, "ign_unmapped");
    rd(32'h00007f05, 32'd3, 1'b0, "addr_lsb_ignored");

    // mid-count PRESET write and disable
    wr(A_PRE, 32'd100);
    wr(A_CTRL, 32'h1);
    rd(A_CNT, 32'd1, 1'b0, "mid_t0");
    rd(A_CNT, 32'd100, 1'b0, "mid_load100");
    wr(A_PRE, 32'd7);
    rd(A_CNT, 32'd98, 1'b0, "mid_preset_no_effect");
    wr(A_CTRL, 32'h0);
    rd(A_CNT, 32'd96, 1'b0, "mid_stop_edge");
    rd(A_CNT, 32'd96, 1'b0, "mid_frozen_a");
    rd(A_CNT, 32'd96, 1'b0, "mid_frozen_b");
    rd(A_PRE, 32'd7, 1'b0, "mid_preset7");
    wr(A_CTRL, 32'h1);
    rd(A_CNT, 32'd96, 1'b0, "mid_reen_t0");
    rd(A_CNT, 32'd7, 1'b0, "mid_reload7");

    // clean reset, then PRESET=0 timing
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd(A_CNT, 32'd0, 1'b0, "rst_pulse_count");
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, 32'h9, 1'b0, "p0_t0");
    rd(A_CNT, 32'd0, 1'b0, "p0_t1");
    rd(A_CNT, 32'd0, 1'b1, "p0_t2_irq");

    // CTRL write colliding with INT in one-shot mode
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h9);
    rd(A_CNT, 32'd0, 1'b0, "coll_t0");
    rd(A_CNT, 32'd2, 1'b0, "coll_t1");
    rd(A_CNT, 32'd1, 1'b0, "coll_t2");
    wrchk(A_CTRL, 32'h9, 32'h9, 1'b1, "coll_in_int");
    rd(A_CTRL, 32'h9, 1'b0, "coll_en_kept");
    rd(A_CNT, 32'd2, 1'b0, "coll_reload");
    rd(A_CNT, 32'd1, 1'b0, "coll_dec");
    rd(A_CNT, 32'd0, 1'b1, "coll_irq");
    rd(A_CTRL, 32'h8, 1'b1, "pre_async_irq");

    // asynchronous reset between edges
    reset = 1'b1;
    rd(A_CNT, 32'd0, 1'b0, "async_rst_irq");
    rd(A_PRE, 32'd0, 1'b0, "async_rst_preset");
    reset = 1'b0;

    end_req = 1'b1;
    @(negedge clk);
    #1 end_req = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
